// File: rtl/reaction_sequencer.sv
// rtl/reaction_sequencer.sv - round controller driving the countdown ms timer for the reaction-time game
module reaction_sequencer #(
  parameter int          MAX_MS       = 2047,
  parameter int          MIN_DELAY_MS = 500,
  parameter int          DELAY_MASK   = 1023,
  parameter int          WIN_MS       = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        button,
  input  logic [$clog2(MAX_MS)-1:0]   timer_value,
  output logic                        timer_enable,
  output logic [$clog2(MAX_MS)-1:0]   timer_start_value,
  output logic                        led_on,
  output logic [$clog2(MAX_MS)-1:0]   result_ms,
  output logic                        result_valid,
  output logic                        false_start,
  output logic                        timeout
);

  localparam int W = $clog2(MAX_MS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_D = 3'd1;
  localparam logic [2:0] S_DELAY  = 3'd2;
  localparam logic [2:0] S_LOAD_W = 3'd3;
  localparam logic [2:0] S_REACT  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [15:0]  MASK16 = DELAY_MASK[15:0];
  localparam logic [W-1:0] MIN_W  = W'(MIN_DELAY_MS);
  localparam logic [W-1:0] WIN_W  = W'(WIN_MS);

  logic [2:0]   state;
  logic [15:0]  lfsr;
  logic         lfsr_fb;
  logic [W-1:0] delay_next;
  logic [W-1:0] react_ms;

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign delay_next = MIN_W + W'(lfsr & MASK16);
  // A timer value above the window cannot happen with a well-behaved timer; clamp so the result never wraps.
  assign react_ms   = (timer_value > WIN_W) ? '0 : (WIN_W - timer_value);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      lfsr              <= LFSR_SEED;
      timer_enable      <= 1'b0;
      timer_start_value <= '0;
      led_on            <= 1'b0;
      result_ms         <= '0;
      result_valid      <= 1'b0;
      false_start       <= 1'b0;
      timeout           <= 1'b0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr_fb};
      result_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            timer_start_value <= delay_next;
            false_start       <= 1'b0;
            timeout           <= 1'b0;
            state             <= S_LOAD_D;
          end
        end
        S_LOAD_D: begin
          timer_enable <= 1'b1;
          state        <= S_DELAY;
        end
        S_DELAY: begin
          if (button) begin
            false_start  <= 1'b1;
            timer_enable <= 1'b0;
            state        <= S_DONE;
          end else if (timer_value == '0) begin
            timer_enable      <= 1'b0;
            timer_start_value <= WIN_W;
            led_on            <= 1'b1;
            state             <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (button) begin
            result_ms    <= '0;
            result_valid <= 1'b1;
            led_on       <= 1'b0;
            state        <= S_DONE;
          end else begin
            timer_enable <= 1'b1;
            state        <= S_REACT;
          end
        end
        S_REACT: begin
          // A press coinciding with expiry still counts as a press of the full window.
          if (button) begin
            result_ms    <= react_ms;
            result_valid <= 1'b1;
            led_on       <= 1'b0;
            timer_enable <= 1'b0;
            state        <= S_DONE;
          end else if (timer_value == '0) begin
            result_ms    <= WIN_W;
            timeout      <= 1'b1;
            led_on       <= 1'b0;
            timer_enable <= 1'b0;
            state        <= S_DONE;
          end
        end
        default: begin
          timer_enable <= 1'b0;
          led_on       <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
